pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised ID->EXE pipeline stage register, successor to the fixed-width stall-vector version.
//  - Replaces the stall[5:0] encoding with a valid/ready handshake.
//  - Adds an explicit valid bit and flush priority.
//  - Exports load-use hazard tags (is_load, rd) to the ID stage.
//  - Optionally adds a 2-entry skid buffer, which cuts the combinational ready path.
// PARAMETERS
//  DATA_W    32          instruction width
//  ADDR_W    32          instruction address width
//  RDATA_W   32          operand width (op1/op2)
//  RADDR_W   5           register-file address width
//  NOP_INST  32'h00000013  bubble instruction (addi x0,x0,0)
//  LOAD_OPC  7'b0000011  opcode[6:0] flagged as a load
// PORTS
//  clk_in            in   1        clock; all state updates on the rising edge
//  reset_in          in   1        asynchronous, active-low reset
//  flush_in          in   1        jump/branch flush; kills all held entries
//  up_valid_in       in   1        ID presents a valid instruction
//  up_ready_out      out  1        stage can accept this cycle
//  inst_in           in   DATA_W   instruction from ID
//  inst_address_in   in   ADDR_W   PC of inst_in
//  op1_in            in   RDATA_W  operand 1
//  op2_in            in   RDATA_W  operand 2
//  reg_waddr_in      in   RADDR_W  destination register
//  reg_we_in         in   1        register write enable
//  down_valid_out    out  1        EXE payload valid
//  down_ready_in     in   1        EXE accepts this cycle (0 = EXE stalled)
//  inst_out          out  DATA_W   to EXE
//  inst_address_out  out  ADDR_W   to EXE
//  op1_out           out  RDATA_W  to EXE
//  op2_out           out  RDATA_W  to EXE
//  reg_waddr_out     out  RADDR_W  to EXE
//  reg_we_out        out  1        to EXE; always 0 when down_valid_out=0
//  inst_is_load_out  out  1        to ID hazard unit; head entry is a valid load
//  rd_out            out  RADDR_W  to ID hazard unit; head inst[11:7], 0 when invalid
// BEHAVIOUR
//  - Reset (reset_in=0, async): all outputs and valid bits clear.
//    - inst_out=NOP_INST; every other output 0.
//    - up_ready_out=1 once reset is released.
//  - Handshake:
//    - Accept on up_valid_in & up_ready_out.
//    - Retire on down_valid_out & down_ready_in.
//    - Latency: 1 cycle from accept to down_valid_out.
//  - Head entry:
//    - Drives all *_out payload.
//    - Held unchanged while down_valid_out=1 and down_ready_in=0.
//    - Upstream values must not leak into the outputs during a hold.
//  - Bubble: head retires and nothing new is accepted -> next cycle:
//    - down_valid_out=0, inst_out=NOP_INST.
//    - op1/op2/reg_waddr/reg_we/inst_is_load/rd all 0.
//    - inst_address_out retains its last value.
//  - Simultaneous retire and accept: new entry becomes the head with no bubble (full throughput).
//  - Flush has priority over every handshake:
//    - Next edge: all valid bits clear and outputs take bubble values.
//    - The cycle's accept is discarded. up_ready_out stays as computed, so ID sees a completed handshake.
//  - Hazard tags:
//    - inst_is_load_out = valid & (inst_out[6:0]==LOAD_OPC).
//    - rd_out = valid ? inst_out[11:7] : 0.
//    - Both are registered with the head and cleared by flush or bubble.
//  - reg_we_out is forced to 0 whenever down_valid_out=0, so EXE never writes from a bubble.
//  - Reset asserted mid-transfer: held entries are dropped immediately and there is no retire.
// CONFIGURATION
//  PIPE_SKID_BUF_EN defined:
//    - Adds a second (skid) entry. up_ready_out = !skid_valid, a registered term.
//    - An accept during a down-stall fills the skid entry.
//    - On the next retire, skid moves to head with order preserved.
//    - Flush clears both entries.
//    - Max occupancy 2. No combinational path from down_ready_in to up_ready_out.
//  PIPE_SKID_BUF_EN undefined:
//    - Single entry. up_ready_out = !down_valid_out | down_ready_in (combinational).
// TESTING
//  1. Reset low with payload driven -> down_valid_out=0, inst_out=00000013, rd_out=0; up_ready_out=1 after release.
//  2. Back-to-back accepts: lw x5 (00002283) then add, down_ready_in=1 ->
//     - cycle 1: inst_is_load_out=1, rd_out=5;
//     - cycle 2: add appears with no bubble.
//  3. down_ready_in=0 for 3 cycles while up_valid_in=1 with new data ->
//     - outputs hold the first entry, reg_we_out unchanged;
//     - without skid, up_ready_out=0 throughout;
//     - with skid, one extra accept, then up_ready_out=0.
//  4. flush_in=1 together with up_valid_in=1 and down stalled ->
//     - next cycle down_valid_out=0, reg_we_out=0, inst_is_load_out=0, inst_out=NOP_INST;
//     - with skid, both entries drained.
//  5. Retire with up_valid_in=0 -> bubble: valid=0, inst_address_out equals last PC (e.g. 0000_0104).
//  6. reset_in pulsed low between edges while two entries are held -> outputs clear immediately, with no clock edge.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: ID->EXE pipeline stage register with a valid/ready handshake,
// flush priority and load-use hazard tags (is_load, rd) exported back to ID.
//
// Build option: define PIPE_SKID_BUF_EN to add a second (skid) entry so that
// up_ready_out is a registered term with no path from down_ready_in.
//
// Ports:
//   clk_in, reset_in (async, active-low)
//   flush_in                 kill every held entry on the next edge
//   up_valid_in/up_ready_out upstream handshake from ID
//   inst_in .. reg_we_in     ID payload
//   down_valid_out/down_ready_in downstream handshake to EXE
//   inst_out .. reg_we_out   EXE payload (head entry, bubble values when invalid)
//   inst_is_load_out, rd_out hazard tags for the ID stage
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       RDATA_W  = 32,
  parameter int unsigned       RADDR_W  = 5,
  parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h0000_0013),
  parameter logic [6:0]        LOAD_OPC = 7'b0000011
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               flush_in,
  input  logic               up_valid_in,
  output logic               up_ready_out,
  input  logic [DATA_W-1:0]  inst_in,
  input  logic [ADDR_W-1:0]  inst_address_in,
  input  logic [RDATA_W-1:0] op1_in,
  input  logic [RDATA_W-1:0] op2_in,
  input  logic [RADDR_W-1:0] reg_waddr_in,
  input  logic               reg_we_in,
  output logic               down_valid_out,
  input  logic               down_ready_in,
  output logic [DATA_W-1:0]  inst_out,
  output logic [ADDR_W-1:0]  inst_address_out,
  output logic [RDATA_W-1:0] op1_out,
  output logic [RDATA_W-1:0] op2_out,
  output logic [RADDR_W-1:0] reg_waddr_out,
  output logic               reg_we_out,
  output logic               inst_is_load_out,
  output logic [RADDR_W-1:0] rd_out
);

  // One held instruction, including its precomputed hazard tags.
  typedef struct packed {
    logic [DATA_W-1:0]  inst;
    logic [ADDR_W-1:0]  addr;
    logic [RDATA_W-1:0] op1;
    logic [RDATA_W-1:0] op2;
    logic [RADDR_W-1:0] waddr;
    logic               we;
    logic               is_load;
    logic [RADDR_W-1:0] rd;
  } entry_t;

  // Bubble payload: NOP, everything cleared, PC retained.
  function automatic entry_t bubble(input logic [ADDR_W-1:0] addr);
    entry_t e;
    e.inst    = NOP_INST;
    e.addr    = addr;
    e.op1     = '0;
    e.op2     = '0;
    e.waddr   = '0;
    e.we      = 1'b0;
    e.is_load = 1'b0;
    e.rd      = '0;
    return e;
  endfunction

  entry_t head_q, head_d, in_entry;
  logic   head_valid_q, head_valid_d;
  logic   accept, retire;

  // Incoming entry with hazard tags derived from the instruction.
  always_comb begin : build_in_entry
    in_entry.inst    = inst_in;
    in_entry.addr    = inst_address_in;
    in_entry.op1     = op1_in;
    in_entry.op2     = op2_in;
    in_entry.waddr   = reg_waddr_in;
    in_entry.we      = reg_we_in;
    in_entry.is_load = (inst_in[6:0] == LOAD_OPC);
    in_entry.rd      = RADDR_W'(inst_in[11:7]);
  end

  assign retire = head_valid_q & down_ready_in;
  assign accept = up_valid_in & up_ready_out;

`ifdef PIPE_SKID_BUF_EN
  entry_t skid_q, skid_d;
  logic   skid_valid_q, skid_valid_d;

  // Ready only depends on skid occupancy, so it is a pure flop output.
  assign up_ready_out = ~skid_valid_q;

  // Next-state: flush beats everything; skid drains into head before new data.
  always_comb begin : next_state
    head_valid_d = head_valid_q;
    head_d       = head_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (flush_in) begin
      head_valid_d = 1'b0;
      head_d       = bubble(head_q.addr);
      skid_valid_d = 1'b0;
    end else if (retire) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        head_valid_d = 1'b1;
        head_d       = in_entry;
      end else begin
        head_valid_d = 1'b0;
        head_d       = bubble(head_q.addr);
      end
    end else if (accept) begin
      if (head_valid_q) begin
        skid_valid_d = 1'b1;
        skid_d       = in_entry;
      end else begin
        head_valid_d = 1'b1;
        head_d       = in_entry;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin : skid_reg
    if (!reset_in) begin
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end
`else
  // Single entry: free when empty or when the head retires this cycle.
  assign up_ready_out = ~head_valid_q | down_ready_in;

  // Next-state: flush beats accept; accept with retire gives full throughput.
  always_comb begin : next_state
    head_valid_d = head_valid_q;
    head_d       = head_q;
    if (flush_in) begin
      head_valid_d = 1'b0;
      head_d       = bubble(head_q.addr);
    end else if (accept) begin
      head_valid_d = 1'b1;
      head_d       = in_entry;
    end else if (retire) begin
      head_valid_d = 1'b0;
      head_d       = bubble(head_q.addr);
    end
  end
`endif

  // Head register; outputs are taken straight from it.
  always_ff @(posedge clk_in or negedge reset_in) begin : head_reg
    if (!reset_in) begin
      head_valid_q <= 1'b0;
      head_q       <= bubble('0);
    end else begin
      head_valid_q <= head_valid_d;
      head_q       <= head_d;
    end
  end

  assign down_valid_out   = head_valid_q;
  assign inst_out         = head_q.inst;
  assign inst_address_out = head_q.addr;
  assign op1_out          = head_q.op1;
  assign op2_out          = head_q.op2;
  assign reg_waddr_out    = head_q.waddr;
  assign reg_we_out       = head_q.we;
  assign inst_is_load_out = head_q.is_load;
  assign rd_out           = head_q.rd;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of pipe_stage_reg against a queue model
// of the stage (capacity 1, or 2 with PIPE_SKID_BUF_EN).
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        up_valid;
  logic        up_ready;
  logic [31:0] inst_d, addr_d, op1_d, op2_d;
  logic [4:0]  waddr_d;
  logic        we_d;
  logic        down_valid;
  logic        down_ready;
  logic [31:0] inst_q, addr_q, op1_q, op2_q;
  logic [4:0]  waddr_q, rd_q;
  logic        we_q, is_load_q;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk_in          (clk),
    .reset_in        (rst_n),
    .flush_in        (flush),
    .up_valid_in     (up_valid),
    .up_ready_out    (up_ready),
    .inst_in         (inst_d),
    .inst_address_in (addr_d),
    .op1_in          (op1_d),
    .op2_in          (op2_d),
    .reg_waddr_in    (waddr_d),
    .reg_we_in       (we_d),
    .down_valid_out  (down_valid),
    .down_ready_in   (down_ready),
    .inst_out        (inst_q),
    .inst_address_out(addr_q),
    .op1_out         (op1_q),
    .op2_out         (op2_q),
    .reg_waddr_out   (waddr_q),
    .reg_we_out      (we_q),
    .inst_is_load_out(is_load_q),
    .rd_out          (rd_q)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  wa;
    logic        we;
  } ent_t;

  // Model: FIFO of held instructions, head at index 0.
  ent_t        q[$];
  logic [31:0] last_addr;
  int          total = 0;
  int          bad   = 0;

  function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] addr,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [4:0] wa, input logic we);
    ent_t e;
    e.inst = inst; e.addr = addr; e.op1 = op1; e.op2 = op2; e.wa = wa; e.we = we;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Stage can take a new instruction when it has room after this cycle's retire.
  function automatic logic model_ready();
`ifdef PIPE_SKID_BUF_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || down_ready;
`endif
  endfunction

  task automatic check_model(input string tag);
    logic [31:0] e_inst, e_addr, e_op1, e_op2;
    logic [4:0]  e_wa, e_rd;
    logic        e_v, e_we, e_ld;
    if (q.size() > 0) begin
      e_v = 1'b1; e_inst = q[0].inst; e_addr = q[0].addr; e_op1 = q[0].op1;
      e_op2 = q[0].op2; e_wa = q[0].wa; e_we = q[0].we;
      e_ld = (q[0].inst[6:0] == 7'b0000011);
      e_rd = q[0].inst[11:7];
    end else begin
      e_v = 1'b0; e_inst = 32'h0000_0013; e_addr = last_addr; e_op1 = '0;
      e_op2 = '0; e_wa = '0; e_we = 1'b0; e_ld = 1'b0; e_rd = '0;
    end
    chk({tag, ".valid"},   32'(down_valid), 32'(e_v));
    chk({tag, ".inst"},    inst_q, e_inst);
    chk({tag, ".addr"},    addr_q, e_addr);
    chk({tag, ".op1"},     op1_q, e_op1);
    chk({tag, ".op2"},     op2_q, e_op2);
    chk({tag, ".waddr"},   32'(waddr_q), 32'(e_wa));
    chk({tag, ".we"},      32'(we_q), 32'(e_we));
    chk({tag, ".is_load"}, 32'(is_load_q), 32'(e_ld));
    chk({tag, ".rd"},      32'(rd_q), 32'(e_rd));
  endtask

  // One cycle: drive at negedge, check ready, advance model at posedge, check outputs.
  task automatic step(input string tag, input logic fl, input logic uv,
                      input logic dr, input ent_t e);
    logic exp_rdy;
    flush = fl; up_valid = uv; down_ready = dr;
    inst_d = e.inst; addr_d = e.addr; op1_d = e.op1; op2_d = e.op2;
    waddr_d = e.wa; we_d = e.we;
    #1;
    exp_rdy = model_ready();
    chk({tag, ".up_ready"}, 32'(up_ready), 32'(exp_rdy));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && dr) void'(q.pop_front());
      if (uv && exp_rdy) q.push_back(e);
    end
    if (q.size() > 0) last_addr = q[0].addr;
    @(negedge clk);
    check_model(tag);
  endtask

  ent_t junk;

  initial begin
    junk = mk(32'hdead_beef, 32'h0000_0f00, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b1);
    q.delete();
    last_addr = '0;

    // Reset held low with live payload upstream.
    rst_n = 1'b0; flush = 1'b0; up_valid = 1'b1; down_ready = 1'b1;
    inst_d = junk.inst; addr_d = junk.addr; op1_d = junk.op1; op2_d = junk.op2;
    waddr_d = junk.wa; we_d = junk.we;
    repeat (3) @(negedge clk);
    check_model("reset");
    chk("reset.inst_lit", inst_q, 32'h0000_0013);
    chk("reset.rd_lit", 32'(rd_q), 32'd0);
    up_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset.ready_lit", 32'(up_ready), 32'd1);

    // Back-to-back load then add, no bubble.
    step("lw", 1'b0, 1'b1, 1'b1, mk(32'h0000_2283, 32'h0000_0100, 32'h10, 32'h20, 5'd5, 1'b1));
    chk("lw.is_load_lit", 32'(is_load_q), 32'd1);
    chk("lw.rd_lit", 32'(rd_q), 32'd5);
    step("add", 1'b0, 1'b1, 1'b1, mk(32'h0031_00b3, 32'h0000_0104, 32'h30, 32'h40, 5'd1, 1'b1));
    chk("add.valid_lit", 32'(down_valid), 32'd1);
    chk("add.inst_lit", inst_q, 32'h0031_00b3);

    // Retire with nothing new: bubble keeps the last PC.
    step("bubble", 1'b0, 1'b0, 1'b1, junk);
    chk("bubble.valid_lit", 32'(down_valid), 32'd0);
    chk("bubble.addr_lit", addr_q, 32'h0000_0104);

    // Downstream stall for three cycles with new data offered.
    step("A", 1'b0, 1'b1, 1'b1, mk(32'h0000_2383, 32'h0000_0108, 32'h50, 32'h60, 5'd7, 1'b1));
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b1, 1'b0,
           mk(32'h0000_0033 | 32'((i + 10) << 7), 32'h0000_010c + 32'(4 * i),
              32'(i), 32'(i + 100), 5'(i + 10), 1'b0));
    chk("stall.inst_lit", inst_q, 32'h0000_2383);
    chk("stall.we_lit", 32'(we_q), 32'd1);
    chk("stall.ready_lit", 32'(up_ready), 32'd0);

    // Flush with an upstream offer while stalled.
    step("flush", 1'b1, 1'b1, 1'b0, junk);
    chk("flush.valid_lit", 32'(down_valid), 32'd0);
    chk("flush.we_lit", 32'(we_q), 32'd0);
    chk("flush.is_load_lit", 32'(is_load_q), 32'd0);
    chk("flush.inst_lit", inst_q, 32'h0000_0013);
    step("drained", 1'b0, 1'b0, 1'b1, junk);
    chk("drained.valid_lit", 32'(down_valid), 32'd0);

    // Mixed traffic with stalls and one flush.
    for (int i = 0; i < 24; i++)
      step("mix", (i == 13), (i % 3 != 0), (i % 4 != 1),
           mk(((i % 2) != 0 ? 32'h0000_2003 : 32'h0000_0033) | 32'((i & 31) << 7),
              32'h0000_0200 + 32'(4 * i), 32'(i * 7), 32'(i * 13), 5'(i), (i % 5 != 0)));

    // Fill the stage, then pulse reset between edges.
    step("E", 1'b0, 1'b1, 1'b1, mk(32'h0000_2503, 32'h0000_0300, 32'h1, 32'h2, 5'd10, 1'b1));
    step("F", 1'b0, 1'b1, 1'b0, mk(32'h0000_0633, 32'h0000_0304, 32'h3, 32'h4, 5'd12, 1'b1));
    up_valid = 1'b0; flush = 1'b0; down_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    last_addr = '0;
    check_model("rst_pulse");
    chk("rst_pulse.inst_lit", inst_q, 32'h0000_0013);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_model("post_rst");
    chk("post_rst.ready_lit", 32'(up_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
